// File: rtl/me_shift_window.sv
// me_shift_window: loadable pixel window that shifts one pixel per request,
// refilling from a small reserve and reporting the pixel shifted out.
module me_shift_window #(
    parameter int PIX_W   = 8,
    parameter int NUM_PIX = 16,
    parameter int RES_PIX = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          load_valid_i,
    output logic                          load_ready_o,
    input  logic [NUM_PIX*PIX_W-1:0]      load_row_i,
    input  logic [RES_PIX*PIX_W-1:0]      load_res_i,
    input  logic                          shift_i,
    input  logic                          dir_i,
    input  logic                          flush_i,
    output logic [NUM_PIX*PIX_W-1:0]      win_o,
    output logic                          win_valid_o,
    output logic [PIX_W-1:0]              spill_o,
    output logic                          spill_valid_o,
    output logic [$clog2(RES_PIX+1)-1:0]  res_cnt_o,
    output logic                          shift_drop_o
);
    localparam int CW    = $clog2(RES_PIX+1);
    localparam int ROW_W = NUM_PIX*PIX_W;
    localparam int RES_W = RES_PIX*PIX_W;

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAINED} state_t;

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   win_q, win_d;
    logic [RES_W-1:0]   res_q, res_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [PIX_W-1:0]   spill_q, spill_d;
    logic               spill_v_q, drop_q;
    logic               load_acc, shift_acc, drop;

    assign load_ready_o = state_q != ACTIVE;
    assign load_acc     = load_valid_i & load_ready_o & ~flush_i;
    assign shift_acc    = shift_i & (state_q == ACTIVE) & ~flush_i;
    assign drop         = shift_i & (state_q != ACTIVE) & ~flush_i;

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        spill_d = spill_q;
        if (flush_i) begin
            state_d = IDLE;
            win_d   = '0;
            res_d   = '0;
            cnt_d   = '0;
        end else if (load_acc) begin
            state_d = ACTIVE;
            win_d   = load_row_i;
            res_d   = load_res_i;
            cnt_d   = CW'(RES_PIX);
        end else if (shift_acc) begin
            // res[0] enters at the end opposite the pixel being spilled
            win_d   = dir_i ? {win_q[ROW_W-PIX_W-1:0], res_q[PIX_W-1:0]}
                            : {res_q[PIX_W-1:0], win_q[ROW_W-1:PIX_W]};
            spill_d = dir_i ? win_q[ROW_W-1 -: PIX_W] : win_q[PIX_W-1:0];
            res_d   = res_q >> PIX_W;
            cnt_d   = cnt_q - CW'(1);
            state_d = (cnt_q == CW'(1)) ? DRAINED : ACTIVE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            win_q     <= '0;
            res_q     <= '0;
            cnt_q     <= '0;
            spill_q   <= '0;
            spill_v_q <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            res_q     <= res_d;
            cnt_q     <= cnt_d;
            spill_q   <= spill_d;
            spill_v_q <= shift_acc;
            drop_q    <= drop;
        end
    end

    assign win_o         = win_q;
    assign win_valid_o   = state_q != IDLE;
    assign spill_o       = spill_q;
    assign spill_valid_o = spill_v_q;
    assign res_cnt_o     = cnt_q;
    assign shift_drop_o  = drop_q;
endmodule

// File: doc/me_shift_window.md
ME_SHIFT_WINDOW -- requirements
Module: me_shift_window

Interface
REQ-001 SHALL have parameter PIX_W, default 8, bits per pixel (>=1).
REQ-002 SHALL have parameter NUM_PIX, default 16, pixels in the window (>=2).
REQ-003 SHALL have parameter RES_PIX, default 2, reserve pixels per load (>=1); CW = $clog2(RES_PIX+1).
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port load_valid_i  input  1  a new row plus reserve is offered.
REQ-007 SHALL have port load_ready_o  output  1  the block can accept a load this cycle.
REQ-008 SHALL have port load_row_i  input  NUM_PIX*PIX_W  window row; pixel k occupies bits [k*PIX_W +: PIX_W].
REQ-009 SHALL have port load_res_i  input  RES_PIX*PIX_W  reserve pixels; res[0] is in the LSBs and is consumed first.
REQ-010 SHALL have port shift_i  input  1  request a one-pixel shift.
REQ-011 SHALL have port dir_i  input  1  0: shift toward pixel 0, new pixel enters at pixel NUM_PIX-1; 1: shift toward pixel NUM_PIX-1, new pixel enters at pixel 0.
REQ-012 SHALL have port flush_i  input  1  synchronous clear to empty.
REQ-013 SHALL have port win_o  output  NUM_PIX*PIX_W  current window, registered.
REQ-014 SHALL have port win_valid_o  output  1  win_o holds loaded data.
REQ-015 SHALL have port spill_o  output  PIX_W  pixel shifted out by the last accepted shift, registered.
REQ-016 SHALL have port spill_valid_o  output  1  one-cycle pulse qualifying spill_o.
REQ-017 SHALL have port res_cnt_o  output  CW  number of unconsumed reserve pixels.
REQ-018 SHALL have port shift_drop_o  output  1  one-cycle pulse: a shift request was ignored.

Function
REQ-019 SHALL implement states IDLE (no data), ACTIVE (window valid, res_cnt>0) and DRAINED (window valid, res_cnt==0).
REQ-020 SHALL drive load_ready_o = 1 in IDLE or DRAINED and 0 in ACTIVE, combinationally from state only.
REQ-021 SHALL accept a load when load_valid_i & load_ready_o: win<=load_row_i, res<=load_res_i, res_cnt<=RES_PIX, win_valid_o<=1, next state ACTIVE.
REQ-022 SHALL accept a shift only in ACTIVE with shift_i=1. With dir_i=0: win <= {res[0], win[NUM_PIX-1:1]} and spill <= pixel 0. With dir_i=1: win <= {win[NUM_PIX-2:0], res[0]} and spill <= pixel NUM_PIX-1.
REQ-023 SHALL, on each accepted shift, shift the reserve down by one pixel (res[i] <= res[i+1], top pixel <= 0), decrement res_cnt and pulse spill_valid_o the following cycle.
REQ-024 SHALL move from ACTIVE to DRAINED on the shift that takes res_cnt from 1 to 0.
REQ-025 SHALL ignore shift_i in IDLE or DRAINED, leave all state unchanged and pulse shift_drop_o the next cycle.
REQ-026 SHALL resolve a load and a shift in the same cycle in DRAINED as follows: the load is taken, the shift is dropped and shift_drop_o pulses.
REQ-027 SHALL give flush_i the highest priority: next state IDLE, win/res/res_cnt/win_valid_o <= 0, no load accepted, no spill or drop pulse.
REQ-028 SHALL have a latency of 1 cycle for all outputs except load_ready_o (0 cycles, state-derived).
REQ-029 SHALL hold win_o, spill_o and res_cnt_o stable in any cycle with no accepted event.

Reset
REQ-030 SHALL, while rst_i is high, force state IDLE and drive win_o, win_valid_o, spill_o, spill_valid_o, res_cnt_o and shift_drop_o to 0; load_ready_o therefore reads 1.
REQ-031 SHALL abandon any in-progress window when reset is asserted mid-operation, with no spill or drop pulse on release.

Verification
REQ-032 SHALL pass the following: defaults; load row pixel k=k (0x00..0x0F), res {0x11,0x10}; shift dir 0 -> win pixels 15..0 = 0x10,0x0F..0x01, spill 0x00 pulse, res_cnt 1; shift again -> top two pixels 0x11,0x10, spill 0x01, res_cnt 0, DRAINED, load_ready_o 1.
REQ-033 SHALL pass the following: same load, one shift dir 1 -> pixel 0 = 0x10, pixel 15 = 0x0E, spill 0x0F.
REQ-034 SHALL pass the following: in DRAINED, shift_i alone -> window unchanged, shift_drop_o one pulse; load+shift together -> new row loaded, res_cnt 2, shift_drop_o pulse, no spill.
REQ-035 SHALL pass the following: flush_i with load_valid_i in IDLE -> remains IDLE, win_valid_o 0, res_cnt_o 0.
REQ-036 SHALL pass the following: rst_i asserted in ACTIVE between clock edges -> all outputs 0 immediately, load_ready_o 1, no pulses after release.
REQ-037 SHALL pass the following: shift_i in IDLE after reset -> shift_drop_o pulse, win_valid_o stays 0.
